// File: rtl/bw_io_jp_bs_pkg.sv
// Shared types and helpers for the boundary-scan chain segment.
// Optional shift-length checker is enabled by defining BW_IO_JP_BS_CNT_EN.
package bw_io_jp_bs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2
  } bs_op_e;

  // Width of the shift counter: room for WIDTH plus headroom to flag over-long scans.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 2;
  endfunction

  // Capture outranks shift when both strobes are high.
  function automatic bs_op_e decode_op(input logic capture_dr, input logic shift_dr);
    if (capture_dr)    return CAPTURE;
    else if (shift_dr) return SHIFT;
    else               return IDLE;
  endfunction

endpackage

// File: rtl/bw_io_jp_bs_cnt.sv
// Saturating shift counter and scan-length compare for bw_io_jp_bs_chain.
// Only instantiated when BW_IO_JP_BS_CNT_EN is defined.
module bw_io_jp_bs_cnt
  import bw_io_jp_bs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  bs_op_e op,
  input  logic   update_dr,
  output logic   len_err
);

  localparam int              CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (op)
        CAPTURE: cnt <= '0;
        SHIFT:   if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // The compare uses the count as it stood before this edge, so a shift on
  // the same edge as update does not count toward this scan.
  always_ff @(posedge clk) begin
    if (rst)            len_err <= 1'b0;
    else if (update_dr) len_err <= (cnt != WIDTH_CNT);
  end

endmodule

// File: rtl/bw_io_jp_bs_chain.sv
// WIDTH-cell boundary-scan register segment: capture/shift/update plus pad mux.
// Defining BW_IO_JP_BS_CNT_EN adds a shift-length checker driving len_err.
module bw_io_jp_bs_chain
  import bw_io_jp_bs_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bsr_si,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             mode_test,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] core_d,
  output logic [WIDTH-1:0] pad_q,
  output logic [WIDTH-1:0] upd_q,
  output logic             bsr_so,
  output logic             len_err
);

  bs_op_e           op;
  logic [WIDTH-1:0] sr;

  assign op = decode_op(capture_dr, shift_dr);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= RST_VAL;
    end else begin
      case (op)
        CAPTURE: sr <= pin_in;
        SHIFT:   sr <= {bsr_si, sr[WIDTH-1:1]};
        default: sr <= sr;
      endcase
    end
  end

  // Update samples the pre-edge shift register, independent of capture/shift.
  always_ff @(posedge clk) begin
    if (rst)            upd_q <= RST_VAL;
    else if (update_dr) upd_q <= sr;
  end

  assign bsr_so = sr[0];
  assign pad_q  = mode_test ? upd_q : core_d;

`ifdef BW_IO_JP_BS_CNT_EN
  bw_io_jp_bs_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .update_dr (update_dr),
    .len_err   (len_err)
  );
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_bw_io_jp_bs_chain.sv
// Self-checking bench for bw_io_jp_bs_chain (WIDTH=8, RST_VAL=8'hA5).
module tb_bw_io_jp_bs_chain;

  localparam int         WIDTH   = 8;
  localparam logic [7:0] RST_VAL = 8'hA5;
`ifdef BW_IO_JP_BS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int CNT_MAX = (1 << ($clog2(WIDTH) + 2)) - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b0;
  logic             bsr_si = 1'b0;
  logic             capture_dr = 1'b0;
  logic             shift_dr = 1'b0;
  logic             update_dr = 1'b0;
  logic             mode_test = 1'b0;
  logic [WIDTH-1:0] pin_in = '0;
  logic [WIDTH-1:0] core_d = '0;
  logic [WIDTH-1:0] pad_q;
  logic [WIDTH-1:0] upd_q;
  logic             bsr_so;
  logic             len_err;

  bw_io_jp_bs_chain #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bsr_si     (bsr_si),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .mode_test  (mode_test),
    .pin_in     (pin_in),
    .core_d     (core_d),
    .pad_q      (pad_q),
    .upd_q      (upd_q),
    .bsr_so     (bsr_so),
    .len_err    (len_err)
  );

  // reference model state
  logic [7:0] sr_m;
  logic [7:0] upd_m;
  int         cnt_m;
  logic       len_m;

  // scoreboard: {upd_q, bsr_so, len_err}
  logic [9:0] exp_q[$];
  logic [7:0] pad_exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one clock of strobes, advance the model, then compare after the edge.
  task automatic cycle(input logic r, input logic cap, input logic sh,
                       input logic upd, input logic si, input logic [7:0] pin);
    logic [9:0] e;
    rst = r; capture_dr = cap; shift_dr = sh; update_dr = upd; bsr_si = si; pin_in = pin;
    if (r) begin
      sr_m = RST_VAL; upd_m = RST_VAL; cnt_m = 0; len_m = 1'b0;
    end else begin
      if (upd) begin
        upd_m = sr_m;
        if (CNT_EN) len_m = (cnt_m != WIDTH);
      end
      if (cap) begin
        sr_m = pin; cnt_m = 0;
      end else if (sh) begin
        sr_m = {si, sr_m[7:1]};
        if (cnt_m < CNT_MAX) cnt_m++;
      end
    end
    exp_q.push_back({upd_m, sr_m[0], len_m});
    @(posedge clk);
    #1;
    rst = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("upd_q",   32'(upd_q),   32'(e[9:2]));
      check_eq("bsr_so",  32'(bsr_so),  32'(e[1]));
      check_eq("len_err", 32'(len_err), 32'(e[0]));
    end
  endtask

  task automatic check_pad(input logic mt, input logic [7:0] cd);
    mode_test = mt; core_d = cd;
    pad_exp_q.push_back(mt ? upd_m : cd);
    #1;
    check_eq("pad_q", 32'(pad_q), 32'(pad_exp_q.pop_front()));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic scan(input int n, input logic [7:0] pattern);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, pattern[i % 8], 8'h00);
  endtask

  initial begin
    logic [7:0] p;
    sr_m = 'x; upd_m = 'x; cnt_m = 0; len_m = 1'b0;
    #1;

    // reset: 2 cycles, pad mux from reset update value
    mode_test = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_pad(1'b1, 8'h5A);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_pad(1'b1, 8'h12);

    // capture 3C, shift out 8 bits with zeros in, then update exposes sr=00
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    scan(8, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check_pad(1'b1, 8'hFF);

    // shift C3 in LSB-first, update, pad mux both ways
    scan(8, 8'hC3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check_pad(1'b1, 8'h0F);
    check_pad(1'b0, 8'h96);
    check_pad(1'b0, 8'($urandom_range(0, 255)));
    check_pad(1'b1, 8'h00);

    // capture+shift together: capture wins
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h6D);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    // shift+update together: update takes pre-shift sr
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    // mid-scan reset, then a normal capture
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hE7);
    scan(3, 8'hFF);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h4B);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check_pad(1'b1, 8'h00);

    // length checks: 7, 8, 300 shifts; also update with no fresh capture
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    scan(7, 8'h5A);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
    scan(8, 8'hA3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
    scan(300, 8'h9C);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
    scan(4, 8'h0F);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    scan(4, 8'hF0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    // random strobe mix
    for (int i = 0; i < 400; i++) begin
      p = 8'($urandom_range(0, 255));
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 8) == 0),
            1'($urandom_range(0, 1)), p);
      if (i % 16 == 0) check_pad(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
